impl_obi_ram_bridge: RTL and testbench
======================================

// Module: impl_obi_ram_bridge
// PURPOSE
// - OBI initiator-side adapter: takes core instr/data OBI requests (req/gnt/rvalid) and drives one port of the byte-enable BRAM.
// - Sits between a cv32e40p fetch or LSU port and the dual-port RAM wrapper; one instance per RAM port.
// - Tracks fixed RAM read latency with a token pipeline.
// - Flags out-of-range accesses with an error response instead of touching the RAM.
// PARAMETERS
// - ADDR_WIDTH   22  width of OBI byte address
// - MEM_AW       17  RAM word-address width; valid byte range is 0 .. 2**(MEM_AW+2)-1
// - RD_LATENCY   2   RAM clk-to-data latency in cycles (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY); legal 1..4
// - LFSR_SEED    8'hA5  stall LFSR seed, nonzero; used only with the macro
// PORTS
// - clk_i          in   1           clock; all logic on posedge
// - rst_i          in   1           asynchronous reset, active-high
// - req_i          in   1           OBI request valid
// - gnt_o          out  1           OBI grant; transfer accepted when req_i && gnt_o
// - addr_i         in   ADDR_WIDTH  OBI byte address
// - we_i           in   1           1 = write
// - be_i           in   4           byte enables
// - wdata_i        in   32          write data
// - rvalid_o       out  1           response valid, single-cycle pulse per accepted request
// - rdata_o        out  32          read data, valid with rvalid_o
// - err_o          out  1           response error, valid with rvalid_o
// - ram_en_o       out  1           RAM port enable
// - ram_addr_o     out  MEM_AW      RAM word address = addr_i[MEM_AW+1:2]
// - ram_we_o       out  4           per-byte write strobes = {4{we_i}} & be_i, only on accepted in-range writes
// - ram_wdata_o    out  32          RAM write data = wdata_i
// - ram_rdata_i    in   32          RAM read data, RD_LATENCY cycles after ram_en_o
// BEHAVIOUR
// - Reset: gnt_o=0 and rvalid_o=0 while rst_i=1. rdata_o=0, err_o=0, ram_en_o=0, ram_we_o=0, token pipe cleared.
// - Grant: gnt_o = req_i (combinational); one transfer per cycle. No backpressure exists without the macro.
// - In-range accept (addr_i[ADDR_WIDTH-1:MEM_AW+2]==0):
//   - ram_en_o=1 in the accept cycle.
//   - RAM outputs are combinational from OBI inputs in the accept cycle and zero otherwise.
// - Out-of-range accept: ram_en_o=0, ram_we_o=0; token tagged err.
// - Token pipe: RD_LATENCY-deep shift register of {valid,err}; stage 0 is loaded at accept.
//   - rvalid_o = last stage valid, i.e. exactly RD_LATENCY cycles after the accept edge.
//   - Writes also receive rvalid_o (rdata_o=0).
// - rdata_o = ram_rdata_i when the token is a read with err=0; 0 otherwise. err_o = token err.
// - Back-to-back accepts produce back-to-back rvalid_o in order. Up to RD_LATENCY outstanding.
// - Read-after-write to the same address in consecutive cycles returns the new data. This relies on the RAM write-first/port ordering; the bridge adds no forwarding.
// - be_i=0 write: accepted, no byte changes, rvalid_o still given.
// - Mid-operation reset: tokens in flight are discarded; no rvalid_o is emitted for them after release.
// - Address wrap: none; the top of range is 2**(MEM_AW+2)-4. The next word is out of range and gives err.
// CONFIGURATION
// - Macro OBI_RAM_BRIDGE_RANDOM_STALL_EN.
// - Defined:
//   - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to LFSR_SEED, advances every cycle.
//   - gnt_o = req_i && (lfsr[1:0]!=2'b00), giving ~25% stall cycles.
//   - Stalled cycle: ram_en_o=0, ram_we_o=0, no token loaded.
//   - Purpose: exercise core req/gnt stall paths.
// - Undefined: no LFSR logic; gnt_o = req_i.
// TESTING
// - Reset: hold rst_i 3 cycles with req_i=1 -> gnt_o=0, rvalid_o=0, ram_en_o=0 throughout.
// - Write then read:
//   - Write 0x100 data 0xDEADBEEF be=4'hF, then read 0x100 (RD_LATENCY=2).
//   - -> ram_we_o=4'hF at cycle 0; rvalid_o at cycles 2 and 3; second rdata_o=0xDEADBEEF, err_o=0.
// - Byte enables:
//   - Write 0x104 0x11223344 be=F, then write 0x104 0xAABBCCDD be=4'b0101, then read.
//   - -> rdata_o=0x11BB33DD.
// - Streaming: 8 consecutive reads 0x0..0x1C -> 8 consecutive rvalid_o pulses in order, no gaps, starting cycle 2.
// - Out of range (MEM_AW=17):
//   - Read 0x80000 -> ram_en_o=0; rvalid_o after 2 cycles with err_o=1, rdata_o=0.
//   - Read 0x7FFFC -> err_o=0.
// - Stall (macro defined): 200 random requests -> responses equal accepted count, in order.
//   - No ram_en_o in non-granted cycles; at least one gnt_o=0 with req_i=1.
//   - Also assert rst_i with 2 outstanding -> no stray rvalid_o after release.

Source files
------------

// File: rtl/impl_obi_ram_bridge_if.sv
// OBI request/response bundle between a core port (master) and the RAM bridge (slave).
interface impl_obi_ram_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 22
);
   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [3:0]            be;
   logic [31:0]           wdata;
   logic                  rvalid;
   logic [31:0]           rdata;
   logic                  err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/impl_obi_ram_bridge.sv
// OBI-to-BRAM port adapter. Grants every request in the same cycle, drives the RAM port
// combinationally on accept, and tracks the fixed RAM read latency with a token pipe so each
// accepted request gets exactly one response, in order. Out-of-range addresses never reach
// the RAM and are answered with err.
// Optional feature: define OBI_RAM_BRIDGE_RANDOM_STALL_EN to insert LFSR-driven grant stalls.
module impl_obi_ram_bridge #(
   parameter int unsigned ADDR_WIDTH = 22,
   parameter int unsigned MEM_AW     = 17,
   parameter int unsigned RD_LATENCY = 2
`ifdef OBI_RAM_BRIDGE_RANDOM_STALL_EN
   ,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
`endif
) (
   input  logic              clk_i,
   input  logic              rst_i,
   impl_obi_ram_bridge_if.slave obi,
   output logic              ram_en_o,
   output logic [MEM_AW-1:0] ram_addr_o,
   output logic [3:0]        ram_we_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   logic accept;
   logic in_range;
   logic stall_ok;

   // One entry per pipeline stage; stage 0 is loaded on accept.
   logic [RD_LATENCY-1:0] tok_vld_q;
   logic [RD_LATENCY-1:0] tok_err_q;
   logic [RD_LATENCY-1:0] tok_rd_q;

`ifdef OBI_RAM_BRIDGE_RANDOM_STALL_EN
   logic [7:0] lfsr_q;

   // Free-running Fibonacci LFSR, taps 8,6,5,4.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign stall_ok = (lfsr_q[1:0] != 2'b00);
`else
   assign stall_ok = 1'b1;
`endif

   // Grant, address decode and the RAM port drive; everything is zero outside an in-range accept.
   always_comb begin
      obi.gnt     = obi.req & ~rst_i & stall_ok;
      accept      = obi.gnt;
      in_range    = (obi.addr[ADDR_WIDTH-1:MEM_AW+2] == '0);
      ram_en_o    = accept & in_range;
      ram_addr_o  = ram_en_o ? obi.addr[MEM_AW+1:2] : '0;
      ram_we_o    = (ram_en_o & obi.we) ? obi.be : 4'b0000;
      ram_wdata_o = ram_en_o ? obi.wdata : 32'h0;
   end

   // Token pipe: shifts {valid, err, is_read} so the response lines up with RAM read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tok_vld_q <= '0;
         tok_err_q <= '0;
         tok_rd_q  <= '0;
      end else begin
         tok_vld_q[0] <= accept;
         tok_err_q[0] <= accept & ~in_range;
         tok_rd_q[0]  <= accept & ~obi.we;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tok_vld_q[i] <= tok_vld_q[i-1];
            tok_err_q[i] <= tok_err_q[i-1];
            tok_rd_q[i]  <= tok_rd_q[i-1];
         end
      end
   end

   // Response side; read data is passed through only for clean read tokens.
   always_comb begin
      obi.rvalid = tok_vld_q[RD_LATENCY-1];
      obi.err    = tok_vld_q[RD_LATENCY-1] & tok_err_q[RD_LATENCY-1];
      obi.rdata  = (tok_vld_q[RD_LATENCY-1] & ~tok_err_q[RD_LATENCY-1] & tok_rd_q[RD_LATENCY-1])
                   ? ram_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_impl_obi_ram_bridge.sv
// Directed bench for impl_obi_ram_bridge with a write-first, 2-cycle-latency byte-enable RAM model.
module tb_impl_obi_ram_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_en;
   logic [16:0] ram_addr;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int checks = 0;
   int errors = 0;

   impl_obi_ram_bridge_if #(.ADDR_WIDTH(22)) obi_if ();

   impl_obi_ram_bridge dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .obi         (obi_if),
      .ram_en_o    (ram_en),
      .ram_addr_o  (ram_addr),
      .ram_we_o    (ram_we),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: write-first, read data appears two cycles after the enable cycle.
   logic [31:0] mem [0:(1<<17)-1];
   logic [31:0] p1 = 32'h0;
   logic [31:0] p2 = 32'h0;
   assign ram_rdata = p2;

   always @(posedge clk) begin
      logic [31:0] w;
      if (ram_en) begin
         w = mem[ram_addr];
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
         end
         mem[ram_addr] = w;
         p1 <= w;
      end
      p2 <= p1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic w, input logic [21:0] a, input logic [3:0] be,
                      input logic [31:0] d);
      obi_if.req   = r;
      obi_if.we    = w;
      obi_if.addr  = a;
      obi_if.be    = be;
      obi_if.wdata = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hB000_0000 + i;
      for (int i = 256; i < (1 << 17); i++) mem[i] = 32'h0;
      mem[17'h1FFFF] = 32'hCAFE_F00D;

      // Reset held with a live request.
      drv(1'b1, 1'b1, 22'h100, 4'hF, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #4;
         chk("rst_gnt", 32'(obi_if.gnt), 32'd0);
         chk("rst_rvalid", 32'(obi_if.rvalid), 32'd0);
         chk("rst_ram_en", 32'(ram_en), 32'd0);
      end
      tick();
      rst = 1'b0;

`ifndef OBI_RAM_BRIDGE_RANDOM_STALL_EN
      // Write then read 0x100.
      drv(1'b1, 1'b1, 22'h100, 4'hF, 32'hDEAD_BEEF);
      #3;
      chk("wr_gnt", 32'(obi_if.gnt), 32'd1);
      chk("wr_ram_en", 32'(ram_en), 32'd1);
      chk("wr_ram_we", 32'(ram_we), 32'hF);
      chk("wr_ram_addr", 32'(ram_addr), 32'h40);
      chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
      tick();
      drv(1'b1, 1'b0, 22'h100, 4'hF, 32'h0);
      #3;
      chk("rd_ram_we", 32'(ram_we), 32'h0);
      chk("rd_ram_en", 32'(ram_en), 32'd1);
      chk("rd_rvalid_early", 32'(obi_if.rvalid), 32'd0);
      tick();
      drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      #3;
      chk("idle_ram_en", 32'(ram_en), 32'd0);
      chk("wr_rvalid", 32'(obi_if.rvalid), 32'd1);
      chk("wr_rdata", obi_if.rdata, 32'h0);
      tick();
      #3;
      chk("rd_rvalid", 32'(obi_if.rvalid), 32'd1);
      chk("rd_rdata", obi_if.rdata, 32'hDEAD_BEEF);
      chk("rd_err", 32'(obi_if.err), 32'd0);
      tick();
      #3;
      chk("rd_rvalid_pulse", 32'(obi_if.rvalid), 32'd0);

      // Byte enables on 0x104.
      tick();
      drv(1'b1, 1'b1, 22'h104, 4'hF, 32'h1122_3344);
      tick();
      drv(1'b1, 1'b1, 22'h104, 4'b0101, 32'hAABB_CCDD);
      tick();
      drv(1'b1, 1'b0, 22'h104, 4'hF, 32'h0);
      tick();
      drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      #3;
      chk("be_wr_rvalid", 32'(obi_if.rvalid), 32'd1);
      tick();
      #3;
      chk("be_rvalid", 32'(obi_if.rvalid), 32'd1);
      chk("be_rdata", obi_if.rdata, 32'h11BB_33DD);

      // be=0 write leaves the word intact but still responds.
      tick();
      drv(1'b1, 1'b1, 22'h108, 4'hF, 32'h0000_0055);
      tick();
      drv(1'b1, 1'b1, 22'h108, 4'h0, 32'h0000_0099);
      #3;
      chk("be0_ram_we", 32'(ram_we), 32'h0);
      chk("be0_ram_en", 32'(ram_en), 32'd1);
      tick();
      drv(1'b1, 1'b0, 22'h108, 4'hF, 32'h0);
      tick();
      drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      #3;
      chk("be0_rvalid", 32'(obi_if.rvalid), 32'd1);
      tick();
      #3;
      chk("be0_rdata", obi_if.rdata, 32'h0000_0055);

      // Streaming: 8 back-to-back reads, responses in cycles 2..9.
      tick();
      for (int k = 0; k <= 10; k++) begin
         drv(k < 8, 1'b0, 22'(k * 4), 4'hF, 32'h0);
         #3;
         chk($sformatf("stream_rvalid_%0d", k), 32'(obi_if.rvalid), 32'(k >= 2 && k < 10));
         if (k >= 2 && k < 10) begin
            chk($sformatf("stream_rdata_%0d", k), obi_if.rdata, 32'hB000_0000 + 32'(k - 2));
         end
         tick();
      end

      // Out-of-range vs top-of-range word.
      drv(1'b1, 1'b0, 22'h80000, 4'hF, 32'h0);
      #3;
      chk("oor_gnt", 32'(obi_if.gnt), 32'd1);
      chk("oor_ram_en", 32'(ram_en), 32'd0);
      tick();
      drv(1'b1, 1'b0, 22'h7FFFC, 4'hF, 32'h0);
      #3;
      chk("top_ram_en", 32'(ram_en), 32'd1);
      chk("top_ram_addr", 32'(ram_addr), 32'h1FFFF);
      tick();
      drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      #3;
      chk("oor_rvalid", 32'(obi_if.rvalid), 32'd1);
      chk("oor_err", 32'(obi_if.err), 32'd1);
      chk("oor_rdata", obi_if.rdata, 32'h0);
      tick();
      #3;
      chk("top_rvalid", 32'(obi_if.rvalid), 32'd1);
      chk("top_err", 32'(obi_if.err), 32'd0);
      chk("top_rdata", obi_if.rdata, 32'hCAFE_F00D);
      tick();
`else
      begin
         int          acc = 0;
         int          resp = 0;
         int          stalls = 0;
         int          cyc = 0;
         logic        pend = 1'b0;
         logic [16:0] wa = '0;
         logic [31:0] expq[$];
         while (acc < 200 && cyc < 3000) begin
            if (!pend) begin
               wa = 17'($urandom_range(0, 255));
               drv($urandom_range(0, 3) != 0, 1'b0, {3'b000, wa, 2'b00}, 4'hF, 32'h0);
            end
            #3;
            if (obi_if.req && !obi_if.gnt) stalls++;
            chk("stall_ram_en", 32'(ram_en), 32'(obi_if.req && obi_if.gnt));
            if (obi_if.rvalid) begin
               resp++;
               if (expq.size() == 0) chk("stall_extra_rvalid", 32'd1, 32'd0);
               else chk("stall_rdata", obi_if.rdata, expq.pop_front());
            end
            if (obi_if.req && obi_if.gnt) begin
               acc++;
               expq.push_back(32'hB000_0000 + 32'(wa));
            end
            pend = obi_if.req && !obi_if.gnt;
            tick();
            cyc++;
         end
         drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
         for (int i = 0; i < 6; i++) begin
            #3;
            if (obi_if.rvalid) begin
               resp++;
               if (expq.size() == 0) chk("stall_extra_rvalid", 32'd1, 32'd0);
               else chk("stall_rdata", obi_if.rdata, expq.pop_front());
            end
            tick();
         end
         chk("stall_budget", 32'(cyc < 3000), 32'd1);
         chk("stall_resp_count", 32'(resp), 32'(acc));
         chk("stall_seen", 32'(stalls > 0), 32'd1);
      end
`endif

      // Mid-operation reset: two requests in flight are dropped.
      drv(1'b1, 1'b0, 22'h0, 4'hF, 32'h0);
      tick();
      drv(1'b1, 1'b0, 22'h4, 4'hF, 32'h0);
      tick();
      drv(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
      rst = 1'b1;
      #3;
      chk("midrst_rvalid", 32'(obi_if.rvalid), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk($sformatf("postrst_rvalid_%0d", i), 32'(obi_if.rvalid), 32'd0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
